axi_pkt_rr_arbiter: RTL and testbench
=====================================

Name: axi_pkt_rr_arbiter

Overview:
- Packet-level round-robin arbiter that shares one AXI-Stream sink, such as the channelizer input FIFO, between NUM_PORTS upstream AXI-Stream sources.
- A grant is held from the first beat of a packet through its tlast beat, so packets are never interleaved.
- Output is a single registered stage that tags each beat with its source port index.
- Sits between per-source axi_fifo instances and the shared downstream datapath.

Parameters:
- NUM_PORTS, 4, number of requesting input streams; range 2..2**PORT_WIDTH.
- PORT_WIDTH, 2, width of the port index and of m_axis_tuser.
- DATA_WIDTH, 32, tdata width per stream.

Ports:
- clk  in  1  single clock for all logic.
- sync_reset_n  in  1  synchronous reset, active-low.
- port_enable  in  NUM_PORTS  per-port arbitration enable; a 0 excludes the port from new grants.
- s_axis_tvalid  in  NUM_PORTS  per-port valid.
- s_axis_tdata  in  NUM_PORTS*DATA_WIDTH  port p occupies bits [p*DATA_WIDTH +: DATA_WIDTH].
- s_axis_tlast  in  NUM_PORTS  per-port end-of-packet.
- s_axis_tready  out  NUM_PORTS  per-port ready; at most one bit high in any cycle.
- m_axis_tvalid  out  1  output valid.
- m_axis_tdata  out  DATA_WIDTH  output data.
- m_axis_tlast  out  1  output end-of-packet.
- m_axis_tuser  out  PORT_WIDTH  source port index of the current beat.
- m_axis_tready  in  1  downstream ready.
- busy  out  1  high while a grant is held (state LOCK).

Behaviour:
- Reset (sync_reset_n=0 at a clk edge):
  - state=IDLE, last_grant=NUM_PORTS-1 (so port 0 has first priority), grant_idx=0.
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, m_axis_tuser=0, s_axis_tready=0, busy=0.
  - Reset mid-packet drops the packet immediately: no tlast is emitted, and the beat held in the output register is discarded.
- Definitions:
  - req[p] = s_axis_tvalid[p] & port_enable[p].
  - out_ready = ~m_axis_tvalid | m_axis_tready.
- FSM IDLE:
  - All s_axis_tready=0.
  - If any req is set, select the first set req scanning last_grant+1, last_grant+2, ..., wrapping modulo NUM_PORTS. Register it as grant_idx and go to LOCK.
  - If no req is set, stay in IDLE.
- FSM LOCK:
  - s_axis_tready[grant_idx] = out_ready; all other s_axis_tready bits are 0.
  - A beat is accepted when s_axis_tvalid[grant_idx] & s_axis_tready[grant_idx].
  - On an accepted beat with tlast=1: last_grant <= grant_idx, go to IDLE.
  - Deasserting port_enable during LOCK does not abort; the packet completes.
  - tvalid gaps from the granted source are tolerated and the grant is held.
- Output stage:
  - On an accepted beat: m_axis_tdata/tlast <= the granted port's data/last, m_axis_tuser <= grant_idx, m_axis_tvalid <= 1.
  - Else if m_axis_tready=1: m_axis_tvalid <= 0. Data registers hold their values.
  - Latency from input accept to m_axis_tvalid is 1 cycle.
  - Full throughput within a packet (1 beat/cycle when m_axis_tready=1).
  - Exactly one bubble cycle (IDLE) between consecutive packets.
- Boundaries:
  - Single-beat packets go IDLE -> LOCK -> IDLE, which is 2 cycles per packet.
  - If only one port requests, it is re-granted after each packet.
  - If req is all-zero in IDLE, no state change.
  - If all ports are disabled, no new grants are issued; an in-flight packet still finishes.
  - Downstream stall (m_axis_tready=0 with m_axis_tvalid=1) forces s_axis_tready=0, and output data is held stable.
  - grant_idx wraps from NUM_PORTS-1 to 0.
  - Indices >= NUM_PORTS are never granted.

Decomposition:
- Shared package axi_pkt_arb_pkg holds:
  - state encoding constants ST_IDLE=1'b0, ST_LOCK=1'b1;
  - the log2 helper function used to check PORT_WIDTH.
- One natural sub-module: rr_arb_select. It is purely combinational. Inputs are req[NUM_PORTS] and last_grant. Outputs are grant_valid and grant_idx[PORT_WIDTH]. It is instantiated once in the IDLE decision path.

Test Plan:
- Reset then all 4 ports valid, 3-beat packets, m_axis_tready=1 -> grant order 0,1,2,3,0.
  - m_axis_tuser matches for each beat.
  - 1 idle cycle between packets.
  - First m_axis_tvalid appears 2 cycles after reset release.
- Only port 2 sends 5 one-beat packets -> five consecutive grants to port 2, one output beat every 2 cycles, tlast=1 on each.
- Port 1 mid-packet (beat 2 of 4) with m_axis_tready held low 3 cycles -> s_axis_tready[1]=0 during the stall, m_axis_tdata stable, no beat lost or duplicated, and port 3 (valid) is not granted until port 1's tlast.
- port_enable=4'b1010 with all ports valid -> only ports 1 and 3 granted, alternating. Clearing port_enable[1] during port 1's packet -> that packet completes, then port 3 is granted repeatedly.
- sync_reset_n pulsed low for 1 cycle during beat 3 of an 8-beat packet from port 0 -> next cycle all outputs 0 and state IDLE, no tlast emitted; the next grant goes to port 0.
- Random valid/tlast/tready on 4 ports for 10k cycles -> per-port output beat order preserved, no interleaving within packets, at most one s_axis_tready bit high per cycle, and no port waits more than 3 packets for a grant.

Source files
------------

// File: rtl/axi_pkt_arb_pkg.sv
// Shared definitions for the packet round-robin arbiter: FSM encoding and a
// ceil-log2 helper used to validate the port index width.
package axi_pkt_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_e;

  function automatic int log2_ceil(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/axi_pkt_rr_arbiter_select.sv
// Combinational round-robin pick: first requesting port after last_grant_i,
// wrapping modulo NUM_PORTS.
module rr_arb_select
  import axi_pkt_arb_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int PORT_WIDTH = 2
) (
  input  logic [NUM_PORTS-1:0]  req_i,
  input  logic [PORT_WIDTH-1:0] last_grant_i,
  output logic                  grant_valid_o,
  output logic [PORT_WIDTH-1:0] grant_idx_o
);

  logic [PORT_WIDTH-1:0] cand;

  // Scan farthest offset first so the nearest requester after last_grant wins.
  always_comb begin
    grant_valid_o = 1'b0;
    grant_idx_o   = '0;
    cand          = '0;
    for (int i = NUM_PORTS; i >= 1; i--) begin
      cand = PORT_WIDTH'((int'(last_grant_i) + i) % NUM_PORTS);
      if (req_i[cand]) begin
        grant_valid_o = 1'b1;
        grant_idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/axi_pkt_rr_arbiter.sv
// Packet-level round-robin arbiter: N AXI-Stream sources onto one registered
// output, grant held from first beat through tlast, beats tagged with port index.
module axi_pkt_rr_arbiter
  import axi_pkt_arb_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int PORT_WIDTH = 2,
  parameter int DATA_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            sync_reset_n,
  input  logic [NUM_PORTS-1:0]            port_enable,
  input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_PORTS-1:0]            s_axis_tlast,
  output logic [NUM_PORTS-1:0]            s_axis_tready,
  output logic                            m_axis_tvalid,
  output logic [DATA_WIDTH-1:0]           m_axis_tdata,
  output logic                            m_axis_tlast,
  output logic [PORT_WIDTH-1:0]           m_axis_tuser,
  input  logic                            m_axis_tready,
  output logic                            busy
);

  if (NUM_PORTS < 2 || PORT_WIDTH < log2_ceil(NUM_PORTS)) begin : g_bad_params
    $error("axi_pkt_rr_arbiter: PORT_WIDTH too small for NUM_PORTS");
  end

  arb_state_e            state_q, state_d;
  logic [PORT_WIDTH-1:0] last_grant_q, last_grant_d;
  logic [PORT_WIDTH-1:0] grant_idx_q, grant_idx_d;
  logic                  m_valid_q, m_last_q;
  logic [DATA_WIDTH-1:0] m_data_q;
  logic [PORT_WIDTH-1:0] m_user_q;

  logic [NUM_PORTS-1:0]  req;
  logic                  out_ready, accept;
  logic                  sel_valid;
  logic [PORT_WIDTH-1:0] sel_idx;
  logic [DATA_WIDTH-1:0] gnt_data;
  logic                  gnt_last;

  assign req       = s_axis_tvalid & port_enable;
  assign out_ready = ~m_valid_q | m_axis_tready;
  assign gnt_data  = s_axis_tdata[DATA_WIDTH*int'(grant_idx_q) +: DATA_WIDTH];
  assign gnt_last  = s_axis_tlast[grant_idx_q];

  rr_arb_select #(
    .NUM_PORTS (NUM_PORTS),
    .PORT_WIDTH(PORT_WIDTH)
  ) u_select (
    .req_i        (req),
    .last_grant_i (last_grant_q),
    .grant_valid_o(sel_valid),
    .grant_idx_o  (sel_idx)
  );

  // Handshake: a beat moves on any edge where valid and ready are both high;
  // valid never waits on ready, and the output register refills in the same
  // cycle it drains (out_ready looks through m_axis_tready).
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    grant_idx_d   = grant_idx_q;
    s_axis_tready = '0;
    accept        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sel_valid) begin
          grant_idx_d = sel_idx;
          state_d     = ST_LOCK;
        end
      end
      ST_LOCK: begin
        s_axis_tready[grant_idx_q] = out_ready;
        accept = s_axis_tvalid[grant_idx_q] & out_ready;
        if (accept && gnt_last) begin
          last_grant_d = grant_idx_q;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!sync_reset_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= PORT_WIDTH'(NUM_PORTS - 1);
      grant_idx_q  <= '0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_last_q     <= 1'b0;
      m_user_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_idx_q  <= grant_idx_d;
      if (accept) begin
        m_valid_q <= 1'b1;
        m_data_q  <= gnt_data;
        m_last_q  <= gnt_last;
        m_user_q  <= grant_idx_q;
      end else if (m_axis_tready) begin
        m_valid_q <= 1'b0;
      end
    end
  end

  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tlast  = m_last_q;
  assign m_axis_tuser  = m_user_q;
  assign busy          = (state_q == ST_LOCK);

endmodule

// File: tb/tb_axi_pkt_rr_arbiter.sv
// Scoreboard bench for axi_pkt_rr_arbiter: per-port source queues drive the
// inputs, a negedge monitor checks every output beat against expected queues.
module tb_axi_pkt_rr_arbiter;

  localparam int NP = 4;
  localparam int PW = 2;
  localparam int DW = 32;

  logic             clk;
  logic             sync_reset_n;
  logic [NP-1:0]    port_enable;
  logic [NP-1:0]    s_axis_tvalid;
  logic [NP*DW-1:0] s_axis_tdata;
  logic [NP-1:0]    s_axis_tlast;
  logic [NP-1:0]    s_axis_tready;
  logic             m_axis_tvalid;
  logic [DW-1:0]    m_axis_tdata;
  logic             m_axis_tlast;
  logic [PW-1:0]    m_axis_tuser;
  logic             m_axis_tready;
  logic             busy;

  axi_pkt_rr_arbiter #(.NUM_PORTS(NP), .PORT_WIDTH(PW), .DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .sync_reset_n (sync_reset_n),
    .port_enable  (port_enable),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tuser (m_axis_tuser),
    .m_axis_tready(m_axis_tready),
    .busy         (busy)
  );

  // ---------------- clock / reset ----------------
  int cyc = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int vec   = 0;
  int fails = 0;
  logic [34:0] exp_q[$];
  logic [34:0] pexp_q[NP][$];
  logic [33:0] src_q[NP][$];
  int          beat_cyc_q[$];
  int          nbeats = 0;
  bit          refill_en = 0;
  bit          rnd_chk = 0;
  int          seq[NP];
  int          wait_cnt[NP];

  function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    vec++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endfunction

  function automatic logic [31:0] mk_data(input int p, input int pkt, input int b);
    return {8'(p), 8'(pkt), 16'(b)};
  endfunction

  task automatic load_pkt(input int p, input int pkt, input int len);
    for (int b = 0; b < len; b++) src_q[p].push_back({b == 0, b == len - 1, mk_data(p, pkt, b)});
  endtask

  task automatic expect_beat(input int p, input int pkt, input int b, input bit last);
    exp_q.push_back({2'(p), last, mk_data(p, pkt, b)});
  endtask

  task automatic expect_pkt(input int p, input int pkt, input int len);
    for (int b = 0; b < len; b++) expect_beat(p, pkt, b, b == len - 1);
  endtask

  task automatic load_rand(input int p);
    int len;
    logic [31:0] d;
    len = $urandom_range(1, 4);
    for (int b = 0; b < len; b++) begin
      d = {8'(p), 24'(seq[p])};
      seq[p]++;
      src_q[p].push_back({b == 0, b == len - 1, d});
      pexp_q[p].push_back({2'(p), b == len - 1, d});
    end
  endtask

  // ---------------- driver: present queue heads, pop on handshake ----------------
  logic [NP-1:0] fire;
  logic [33:0]   w;
  initial begin
    s_axis_tvalid = '0;
    s_axis_tdata  = '0;
    s_axis_tlast  = '0;
    forever begin
      @(negedge clk);
      fire = s_axis_tvalid & s_axis_tready & {NP{sync_reset_n}};
      @(posedge clk);
      #1;
      for (int p = 0; p < NP; p++) begin
        if (fire[p] && src_q[p].size() > 0) void'(src_q[p].pop_front());
        if (refill_en && src_q[p].size() == 0) load_rand(p);
        if (src_q[p].size() > 0) begin
          w = src_q[p][0];
          s_axis_tvalid[p] = !(refill_en && !w[33] && $urandom_range(0, 3) == 0);
          s_axis_tlast[p]  = w[32];
          s_axis_tdata[p*DW +: DW] = w[31:0];
        end else begin
          s_axis_tvalid[p] = 1'b0;
          s_axis_tlast[p]  = 1'b0;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  bit          stall_prev = 0;
  logic [34:0] stall_word;
  bit          in_pkt = 0;
  int          cur_port = 0;
  always @(negedge clk) begin
    logic [34:0] got, ex;
    int u;
    got = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
    u   = int'(m_axis_tuser);
    chk("tready_onehot0", 64'($countones(s_axis_tready) <= 1), 64'd1);
    if (stall_prev && m_axis_tvalid) chk("stall_hold", 64'(got), 64'(stall_word));
    stall_prev = m_axis_tvalid && !m_axis_tready && sync_reset_n;
    stall_word = got;
    if (m_axis_tvalid && m_axis_tready) begin
      nbeats++;
      beat_cyc_q.push_back(cyc);
      if (rnd_chk) begin
        if (pexp_q[u].size() == 0) begin
          vec++; fails++;
          $display("FAIL rnd_unexpected: got %0h expected nothing from port %0d", got, u);
        end else begin
          ex = pexp_q[u].pop_front();
          chk("rnd_beat", 64'(got), 64'(ex));
        end
        if (in_pkt) chk("no_interleave", 64'(u), 64'(cur_port));
        in_pkt   = !m_axis_tlast;
        cur_port = u;
        if (m_axis_tlast) begin
          for (int q = 0; q < NP; q++) begin
            if (q == u) wait_cnt[q] = 0;
            else if (src_q[q].size() > 0) begin
              wait_cnt[q]++;
              chk("fair_wait", 64'(wait_cnt[q] <= 3), 64'd1);
            end
          end
        end
      end else if (exp_q.size() == 0) begin
        vec++; fails++;
        $display("FAIL unexpected_beat: got %0h expected none", got);
      end else begin
        ex = exp_q.pop_front();
        chk("beat", 64'(got), 64'(ex));
      end
    end
  end

  // ---------------- test helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin tick(1); n++; end
    chk({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    tick(2);
  endtask

  task automatic wait_beats(input string name, input int k, input int budget);
    int n = 0;
    while (nbeats < k && n < budget) begin tick(1); n++; end
    chk({name, "_beats_seen"}, 64'(nbeats >= k), 64'd1);
  endtask

  task automatic chk_idle_outputs(input string name);
    chk({name, "_tvalid"}, 64'(m_axis_tvalid), 64'd0);
    chk({name, "_tdata"},  64'(m_axis_tdata),  64'd0);
    chk({name, "_tlast"},  64'(m_axis_tlast),  64'd0);
    chk({name, "_tuser"},  64'(m_axis_tuser),  64'd0);
    chk({name, "_tready"}, 64'(s_axis_tready), 64'd0);
    chk({name, "_busy"},   64'(busy),          64'd0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int rel;
    sync_reset_n  = 1'b0;
    m_axis_tready = 1'b1;
    port_enable   = 4'hF;
    for (int p = 0; p < NP; p++) begin seq[p] = 0; wait_cnt[p] = 0; end
    @(posedge clk);
    tick(3);
    chk_idle_outputs("reset");

    // all ports, 3-beat packets: grant order 0,1,2,3,0
    load_pkt(0, 0, 3); load_pkt(1, 0, 3); load_pkt(2, 0, 3); load_pkt(3, 0, 3); load_pkt(0, 1, 3);
    expect_pkt(0, 0, 3); expect_pkt(1, 0, 3); expect_pkt(2, 0, 3); expect_pkt(3, 0, 3); expect_pkt(0, 1, 3);
    tick(1);
    beat_cyc_q.delete();
    sync_reset_n = 1'b1;
    rel = cyc;
    wait_drain("rr4", 60);
    chk("rr4_beat_count", 64'(beat_cyc_q.size()), 64'd15);
    if (beat_cyc_q.size() == 15) begin
      chk("first_latency", 64'(beat_cyc_q[0] - rel), 64'd2);
      for (int i = 1; i < 15; i++)
        chk("rr4_spacing", 64'(beat_cyc_q[i] - beat_cyc_q[i-1]), (i % 3 == 0) ? 64'd2 : 64'd1);
    end

    // single requester, one-beat packets: one beat every 2 cycles
    beat_cyc_q.delete();
    for (int k = 0; k < 5; k++) begin load_pkt(2, k, 1); expect_pkt(2, k, 1); end
    wait_drain("single", 40);
    chk("single_beat_count", 64'(beat_cyc_q.size()), 64'd5);
    if (beat_cyc_q.size() == 5)
      for (int i = 1; i < 5; i++) chk("single_spacing", 64'(beat_cyc_q[i] - beat_cyc_q[i-1]), 64'd2);

    // downstream stall mid-packet; port 3 must wait for port 1's tlast
    nbeats = 0;
    load_pkt(1, 0, 4);
    expect_pkt(1, 0, 4); expect_pkt(3, 0, 2);
    wait_beats("stall", 1, 20);
    load_pkt(3, 0, 2);
    m_axis_tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("stall_src_tready", 64'(s_axis_tready), 64'd0);
      chk("stall_out_valid", 64'(m_axis_tvalid), 64'd1);
    end
    @(posedge clk); #3;
    m_axis_tready = 1'b1;
    wait_drain("stall", 40);

    // enable mask 1010, then drop port 1 mid-packet
    port_enable = 4'b1010;
    load_pkt(0, 1, 2); load_pkt(2, 5, 2);
    load_pkt(1, 1, 3); load_pkt(1, 2, 3); load_pkt(1, 3, 3);
    load_pkt(3, 1, 3); load_pkt(3, 2, 3); load_pkt(3, 3, 3);
    expect_pkt(1, 1, 3); expect_pkt(3, 1, 3); expect_pkt(1, 2, 3); expect_pkt(3, 2, 3); expect_pkt(3, 3, 3);
    begin
      int n = 0;
      while (src_q[1].size() != 5 && n < 60) begin tick(1); n++; end
      chk("enmask_reach_mid_pkt", 64'(src_q[1].size()), 64'd5);
    end
    port_enable = 4'b1000;
    wait_drain("enmask", 60);
    port_enable = 4'b0000;
    tick(1);
    for (int i = 0; i < 4; i++) begin
      chk("disabled_busy", 64'(busy), 64'd0);
      chk("disabled_tvalid", 64'(m_axis_tvalid), 64'd0);
      tick(1);
    end
    for (int p = 0; p < NP; p++) src_q[p].delete();
    tick(2);
    port_enable = 4'hF;

    // reset pulse while beat 3 of an 8-beat packet is on the input
    nbeats = 0;
    load_pkt(0, 7, 8);
    expect_beat(0, 7, 0, 1'b0); expect_beat(0, 7, 1, 1'b0);
    wait_beats("rstmid", 1, 20);
    sync_reset_n = 1'b0;
    tick(1);
    chk_idle_outputs("rstmid");
    chk("rstmid_expected_consumed", 64'(exp_q.size()), 64'd0);
    for (int p = 0; p < NP; p++) src_q[p].delete();
    sync_reset_n = 1'b1;
    load_pkt(1, 0, 2); load_pkt(0, 8, 2);
    expect_pkt(0, 8, 2); expect_pkt(1, 0, 2);
    wait_drain("post_rst", 30);

    // random traffic with per-port ordering and fairness checks
    rnd_chk   = 1;
    refill_en = 1;
    for (int i = 0; i < 10000; i++) begin
      m_axis_tready = ($urandom_range(0, 3) != 0);
      tick(1);
    end
    refill_en     = 0;
    m_axis_tready = 1'b1;
    begin
      int n = 0;
      while ((pexp_q[0].size() + pexp_q[1].size() + pexp_q[2].size() + pexp_q[3].size()) > 0 && n < 300) begin
        tick(1); n++;
      end
    end
    for (int p = 0; p < NP; p++) chk("rnd_drained", 64'(pexp_q[p].size()), 64'd0);
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", vec, fails);
    $finish;
  end

endmodule
